dense_to_coo_encoder: RTL and testbench
=======================================

# dense_to_coo_encoder

Sequential compressor that accepts one dense 4x4 matrix of 32-bit words and emits its nonzero entries as a stream of COO tuples (data, row, col) over a valid/ready handshake. It is the producer side of the COO format consumed by `sparse_coo_matmul`: its output stream is collected into the 4-slot A/B operand banks of that multiplier, and it flags matrices whose nonzero count exceeds the slot capacity.

## Interface
Parameters:
- `DATA_W`, 32: element width.
- `MAX_NNZ`, 4: maximum entries emitted per matrix, matching the 4-slot COO operand bank.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: dense matrix on `in_data` is valid.
- `in_ready`  out  1: the block accepts a matrix this cycle.
- `in_data`  in  16*DATA_W: row-major dense matrix; element (r,c) occupies bits [(4r+c)*DATA_W +: DATA_W].
- `out_valid`  out  1: COO tuple valid.
- `out_ready`  in  1: downstream accepts the tuple.
- `out_data`  out  DATA_W: nonzero value.
- `out_row`  out  2: row index.
- `out_col`  out  2: column index.
- `out_last`  out  1: final tuple of this matrix; qualified by `out_valid`.
- `done`  out  1: one-cycle pulse when the matrix is fully processed.
- `nnz_count`  out  3: tuples emitted for the last matrix; held until the next `done`.
- `overflow`  out  1: last matrix had more than MAX_NNZ nonzeros; held until the next `done`.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, latch `in_data`, compute the 16-bit nonzero mask (element != 0), clear `idx` and the emitted counter, and go to SCAN.
- SCAN: examine element `idx` (row-major, 0..15); `out_row`=idx[3:2], `out_col`=idx[1:0].
  - Zero element: `out_valid`=0; `idx`++ after one cycle.
  - Nonzero element: `out_valid`=1; hold the tuple stable until `out_valid && out_ready`, then increment `idx` and the emitted counter.
  - `out_last`=1 when the current element is nonzero and either no mask bit above `idx` is set, or the emitted counter equals MAX_NNZ-1.
  - Leave for DONE when a handshake occurs with `out_last`=1, or when `idx`=15 and the element is zero.
  - `overflow` is computed at the `out_last` handshake: set when mask bits remain above `idx`. The dropped entries are never emitted.
- DONE: for one cycle, `done`=1; `nnz_count` and `overflow` are updated. Next state is IDLE.
- An all-zero matrix scans 16 cycles, emits no tuples, and ends with `done` and `nnz_count`=0.
- `in_ready`=0 in SCAN and DONE. A new matrix cannot be accepted in the DONE cycle.
- `out_data`, `out_row`, `out_col` and `out_last` do not change while `out_valid && !out_ready`.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out_last`=0, `done`=0, `nnz_count`=0, `overflow`=0; `out_data`/`out_row`/`out_col`=0.
- `rst` asserted mid-scan: returns to IDLE on the next edge. The pending tuple is discarded without a handshake, and no `done` is produced.
- The matrix is accepted at edge T. Element 0 is examined in the cycle after T (SCAN cycle 0).
- With `out_ready` held at 1, element k is presented in SCAN cycle k.
- Each stalled cycle (`out_valid && !out_ready`) adds one cycle.
- `done` is asserted in the cycle after the final SCAN cycle.
- Minimum matrix-to-matrix period: 16 SCAN + 1 DONE + 1 IDLE = 18 cycles (full scan, no early termination).
- `out_valid` never depends combinationally on `out_ready`.

## Test plan
- Reset: assert `rst` for 2 cycles -> all outputs at their reset values and `in_ready`=1.
- Basic: A[0][1]=2, A[1][2]=3, A[2][3]=4, other elements 0, `out_ready`=1 -> tuples (2,0,1), (3,1,2), (4,2,3) in SCAN cycles 1, 6 and 11; `out_last` on the third tuple; `done` in the next cycle; `nnz_count`=3, `overflow`=0.
- Backpressure: same matrix, `out_ready`=0 for 5 cycles while (3,1,2) is presented -> tuple held stable; third tuple appears 5 cycles later than in the basic case; same final counts.
- Overflow: six nonzeros at indices 0..5 with values 1..6 -> tuples 1..4 emitted, `out_last` on value 4, `done` follows, `nnz_count`=4, `overflow`=1.
- All-zero matrix -> no `out_valid` for 16 SCAN cycles, then `done` with `nnz_count`=0; a dense matrix with a single nonzero A[3][3]=9 -> tuple (9,3,3) with `out_last`=1 in SCAN cycle 15.
- Reset during SCAN while a tuple is stalled -> next cycle: IDLE, `out_valid`=0, no `done`. A following matrix is processed correctly from index 0.

Source files
------------

// File: rtl/dense_to_coo_encoder.sv
// Dense 4x4 matrix to COO tuple stream compressor.
// Emits up to MAX_NNZ nonzero (data,row,col) tuples per matrix over valid/ready.
module dense_to_coo_encoder #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_NNZ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*DATA_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [1:0]           out_row,
  output logic [1:0]           out_col,
  output logic                 out_last,
  output logic                 done,
  output logic [2:0]           nnz_count,
  output logic                 overflow
);

  localparam int unsigned N_ELEM = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_NNZ - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [N_ELEM-1:0]     r_mask, w_mask_nxt, w_in_mask;
  logic [DATA_W-1:0]     r_mat [N_ELEM];
  logic [DATA_W-1:0]     w_mat_nxt [N_ELEM];
  logic [DATA_W-1:0]     w_in_mat [N_ELEM];
  logic [CNT_W-1:0]      w_nnz_nxt;
  logic                  w_ovf_nxt;
  logic                  w_cur_nz, w_cur_last;
  logic                  w_valid_nxt, w_last_nxt;
  logic [DATA_W-1:0]     w_data_nxt;
  logic [1:0]            w_row_nxt, w_col_nxt;

  // True when any mask bit strictly above position i is set.
  function automatic logic any_above(input logic [N_ELEM-1:0] m, input logic [IDX_W-1:0] i);
    return |(m & ~((16'd2 << i) - 16'd1));
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_mask_nxt  = r_mask;
    w_mat_nxt   = r_mat;
    w_nnz_nxt   = nnz_count;
    w_ovf_nxt   = overflow;

    for (int i = 0; i < int'(N_ELEM); i++) begin
      w_in_mat[i]  = in_data[i*DATA_W +: DATA_W];
      w_in_mask[i] = |w_in_mat[i];
    end

    w_cur_nz   = r_mask[r_idx];
    w_cur_last = w_cur_nz && (!any_above(r_mask, r_idx) || (r_cnt == LAST_CNT));

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_mat_nxt   = w_in_mat;
          w_mask_nxt  = w_in_mask;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!w_cur_nz) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_DONE;
            w_nnz_nxt   = r_cnt;
            w_ovf_nxt   = 1'b0;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end else if (out_ready) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (w_cur_last) begin
            w_state_nxt = S_DONE;
            w_nnz_nxt   = r_cnt + CNT_W'(1);
            w_ovf_nxt   = any_above(r_mask, r_idx);
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Output registers are loaded from next-state values so ports are flop-driven.
    w_valid_nxt = (w_state_nxt == S_SCAN) && w_mask_nxt[w_idx_nxt];
    w_last_nxt  = w_valid_nxt &&
                  (!any_above(w_mask_nxt, w_idx_nxt) || (w_cnt_nxt == LAST_CNT));
    w_data_nxt  = (w_state_nxt == S_SCAN) ? w_mat_nxt[w_idx_nxt] : '0;
    w_row_nxt   = (w_state_nxt == S_SCAN) ? w_idx_nxt[3:2] : 2'd0;
    w_col_nxt   = (w_state_nxt == S_SCAN) ? w_idx_nxt[1:0] : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_mask    <= '0;
      r_mat     <= '{default: '0};
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      done      <= 1'b0;
      nnz_count <= '0;
      overflow  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mask    <= w_mask_nxt;
      r_mat     <= w_mat_nxt;
      in_ready  <= (w_state_nxt == S_IDLE);
      out_valid <= w_valid_nxt;
      out_last  <= w_last_nxt;
      out_data  <= w_data_nxt;
      out_row   <= w_row_nxt;
      out_col   <= w_col_nxt;
      done      <= (w_state_nxt == S_DONE);
      nnz_count <= w_nnz_nxt;
      overflow  <= w_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_dense_to_coo_encoder.sv
// Scoreboard bench for dense_to_coo_encoder: expected tuples queued from a
// reference model at stimulus time and popped at each output handshake.
module tb_dense_to_coo_encoder;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MAX_NNZ = 4;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [1:0]        row;
    logic [1:0]        col;
    logic              last;
    int                cyc;
  } tup_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [16*DATA_W-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_data;
  logic [1:0]           out_row;
  logic [1:0]           out_col;
  logic                 out_last;
  logic                 done;
  logic [2:0]           nnz_count;
  logic                 overflow;

  dense_to_coo_encoder #(.DATA_W(DATA_W), .MAX_NNZ(MAX_NNZ)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .done(done), .nnz_count(nnz_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int   cmp_cnt = 0;
  int   err_cnt = 0;
  tup_t sb[$];
  int   exp_done;
  logic [2:0] exp_nnz;
  logic       exp_ovf;
  logic [DATA_W-1:0] m [16];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: row-major scan, first MAX_NNZ nonzeros, handshake cycle
  // delayed by stall_n for the stalled tuple and all that follow it.
  task automatic load_model(input logic [DATA_W-1:0] mm [16], input int stall_ord, input int stall_n);
    tup_t t;
    int   n;
    sb.delete();
    n = 0;
    exp_ovf = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (mm[i] != '0) begin
        if (n < int'(MAX_NNZ)) begin
          t.data = mm[i];
          t.row  = 2'(i / 4);
          t.col  = 2'(i % 4);
          t.last = 1'b0;
          t.cyc  = i + ((n >= stall_ord) ? stall_n : 0);
          sb.push_back(t);
          n++;
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
    if (n > 0) begin
      t = sb[n-1];
      t.last = 1'b1;
      sb[n-1] = t;
      exp_done = t.cyc + 1;
    end else begin
      exp_done = 16;
    end
    exp_nnz = 3'(n);
  endtask

  task automatic run_matrix(input logic [DATA_W-1:0] mm [16], input int stall_ord,
                            input int stall_n, input string name);
    int   k, ord, stalled;
    bit   fin;
    tup_t t;
    load_model(mm, stall_ord, stall_n);
    @(negedge clk);
    for (int i = 0; i < 16; i++) in_data[i*DATA_W +: DATA_W] = mm[i];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check_val({name, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    k = 0; ord = 0; stalled = 0; fin = 1'b0;
    while (!fin && k < 60) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (k == 0) check_val({name, "_in_ready_scan"}, 32'(in_ready), 32'd0);
      if (out_valid && ord == stall_ord && stalled < stall_n) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
      if (done) begin
        check_val({name, "_done_cycle"}, 32'(k), 32'(exp_done));
        check_val({name, "_nnz"}, 32'(nnz_count), 32'(exp_nnz));
        check_val({name, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        check_val({name, "_pending"}, 32'(sb.size()), 32'd0);
        check_val({name, "_in_ready_done"}, 32'(in_ready), 32'd0);
        fin = 1'b1;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          check_val({name, "_unexpected_tuple"}, 32'(out_valid), 32'd0);
        end else begin
          t = sb[0];
          check_val({name, "_data"}, out_data, t.data);
          check_val({name, "_row"}, 32'(out_row), 32'(t.row));
          check_val({name, "_col"}, 32'(out_col), 32'(t.col));
          check_val({name, "_last"}, 32'(out_last), 32'(t.last));
          if (out_ready) begin
            check_val({name, "_hs_cycle"}, 32'(k), 32'(t.cyc));
            void'(sb.pop_front());
            ord++;
          end
        end
      end
      if (!fin) begin
        @(posedge clk);
        k++;
      end
    end
    check_val({name, "_done_seen"}, 32'(fin), 32'd1);
    @(negedge clk);
    check_val({name, "_done_pulse"}, 32'(done), 32'd0);
    check_val({name, "_in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_last", 32'(out_last), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_nnz", 32'(nnz_count), 32'd0);
    check_val("rst_ovf", 32'(overflow), 32'd0);
    check_val("rst_data", out_data, 32'd0);
    check_val("rst_rowcol", 32'({out_row, out_col}), 32'd0);
    rst = 1'b0;

    m = '{default: '0}; m[1] = 2; m[6] = 3; m[11] = 4;
    run_matrix(m, 99, 0, "basic");
    run_matrix(m, 1, 5, "bp");

    m = '{default: '0};
    for (int i = 0; i < 6; i++) m[i] = 32'(i + 1);
    run_matrix(m, 99, 0, "ovf");

    m = '{default: '0};
    run_matrix(m, 99, 0, "zero");

    m[15] = 9;
    run_matrix(m, 99, 0, "single33");

    m = '{default: '0}; m[3] = 5; m[7] = 6; m[12] = 7; m[15] = 8;
    run_matrix(m, 2, 3, "four");

    for (int i = 0; i < 16; i++) m[i] = ($urandom_range(0, 2) == 0) ? $urandom : '0;
    run_matrix(m, 0, 2, "rand");

    // Reset while the first tuple of an overflow matrix is stalled.
    m = '{default: '0};
    for (int i = 0; i < 6; i++) m[i] = 32'(i + 1);
    @(negedge clk);
    for (int i = 0; i < 16; i++) in_data[i*DATA_W +: DATA_W] = m[i];
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_val("mid_stall_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    check_val("mid_rst_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_done", 32'(done), 32'd0);
    check_val("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check_val("mid_rst_nnz", 32'(nnz_count), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_val("mid_rst_no_done", 32'(done), 32'd0);

    m = '{default: '0}; m[1] = 2; m[6] = 3; m[11] = 4;
    run_matrix(m, 99, 0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
